// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM word address, registers instruction/PC for decode,
// handles execute redirects and sticky fetch faults. Optional counters: FETCH_PERF_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_RUN    | normal fetch, redirect and fault checks active
// ST_FAULT  | terminal after a bad fetch PC, left only by rst
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 8,
  parameter int              ROM_DEPTH = 58,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalled,
  output logic [31:0]       perf_flushed,
`endif
  output logic              fault,
  output logic [XLEN-1:0]   fault_pc
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [XLEN-3:0] ROM_LIMIT = (XLEN-2)'(ROM_DEPTH);

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            out_of_range;
  logic            fetch_bad;
  logic            running;
  logic            load;

  // High PC bits are dropped here; the range check below keeps them from aliasing.
  assign rom_addr     = pc[ADDR_W+1:2];

  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = (pc[XLEN-1:2] >= ROM_LIMIT);
  assign fetch_bad    = misaligned || out_of_range;
  assign running      = (state == ST_RUN);
  assign load         = (!out_valid || out_ready) && running && !redirect_valid && !fetch_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
      fault_pc  <= '0;
    end else if (running) begin
      if (redirect_valid) begin
        pc        <= redirect_pc;
        out_valid <= 1'b0;
      end else if (fetch_bad) begin
        state     <= ST_FAULT;
        fault     <= 1'b1;
        fault_pc  <= pc;
        out_valid <= 1'b0;
      end else if (load) begin
        out_instr <= rom_instr;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counters only advance in RUN, so they freeze once a fault is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
      perf_flushed <= '0;
    end else if (running) begin
      if (load)
        perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready)
        perf_stalled <= perf_stalled + 32'd1;
      if (redirect_valid && out_valid)
        perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, a stream-level reference model
// compared every cycle, and literal expectations at the interesting points.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalled, perf_flushed;
`endif

  logic [31:0] rom [256];
  int tests = 0;
  int fails = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_instr(rom_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stalled(perf_stalled), .perf_flushed(perf_flushed),
`endif
    .fault(fault), .fault_pc(fault_pc)
  );

  assign rom_instr = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch unit as a stream of PCs, issued one per accepted slot.
  logic [31:0] m_next_pc = 32'h0;
  logic        m_valid   = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_instr   = 32'h0;
  logic        m_fault   = 1'b0;
  logic [31:0] m_fpc     = 32'h0;

  function automatic bit bad_pc(input logic [31:0] p);
    return (p % 4 != 0) || (p / 4 >= 58);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_next_pc = 32'h0; m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
      m_fault = 1'b0; m_fpc = 32'h0;
    end else if (!m_fault) begin
      if (redirect_valid) begin
        m_next_pc = redirect_pc;
        m_valid   = 1'b0;
      end else if (bad_pc(m_next_pc)) begin
        m_fault = 1'b1;
        m_fpc   = m_next_pc;
        m_valid = 1'b0;
      end else if (!m_valid || out_ready) begin
        m_valid   = 1'b1;
        m_pc      = m_next_pc;
        m_instr   = rom[(m_next_pc / 4) % 256];
        m_next_pc = m_next_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("model_fault", {31'd0, fault}, {31'd0, m_fault});
      check("model_fault_pc", fault_pc, m_fpc);
      check("model_rom_addr", {24'd0, rom_addr}, (m_next_pc / 4) % 256);
      if (m_valid) begin
        check("model_out_pc", out_pc, m_pc);
        check("model_out_instr", out_instr, m_instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h0150_0093;
    rom[1] = 32'h0070_0113;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_fault_pc", fault_pc, 32'h0);

    // sequential fetch after reset
    check("seq_rom_addr0", {24'd0, rom_addr}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("seq_pc0", out_pc, 32'h0);
    check("seq_instr0", out_instr, 32'h0150_0093);
    check("seq_rom_addr1", {24'd0, rom_addr}, 32'd1);
    @(negedge clk);
    check("seq_pc1", out_pc, 32'h4);
    check("seq_instr1", out_instr, 32'h0070_0113);
    check("seq_rom_addr2", {24'd0, rom_addr}, 32'd2);

    // three-cycle stall
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_pc", out_pc, 32'h4);
      check("stall_instr", out_instr, 32'h0070_0113);
      check("stall_rom_addr", {24'd0, rom_addr}, 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("after_stall_pc", out_pc, 32'h8);
    @(negedge clk);
    check("after_stall_pc2", out_pc, 32'hC);

    // redirect while stalled
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_redir_pc", out_pc, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'hB0;
    @(negedge clk);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    check("redir_rom_addr", {24'd0, rom_addr}, 32'd44);
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("redir_target_valid", {31'd0, out_valid}, 32'd1);
    check("redir_target_pc", out_pc, 32'hB0);
    check("redir_target_instr", out_instr, 32'hA000_002C);

    // redirect to misaligned address
    redirect_valid = 1'b1; redirect_pc = 32'h06;
    @(negedge clk);
    check("mis_no_fault_yet", {31'd0, fault}, 32'd0);
    check("mis_valid0", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'h06);
    check("mis_valid1", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h00;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_sticky", {31'd0, fault}, 32'd1);
    check("fault_redir_ignored", {24'd0, rom_addr}, 32'd1);
    check("fault_no_valid", {31'd0, out_valid}, 32'd0);

    // run off the end of the ROM
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hE0;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("end_rom_addr", {24'd0, rom_addr}, 32'd56);
    @(negedge clk);
    check("end_pc56", out_pc, 32'hE0);
    check("end_instr56", out_instr, 32'hA000_0038);
    @(negedge clk);
    check("end_pc57", out_pc, 32'hE4);
    check("end_no_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    check("end_fault", {31'd0, fault}, 32'd1);
    check("end_fault_pc", fault_pc, 32'hE8);
    check("end_valid", {31'd0, out_valid}, 32'd0);

    // aliasing target: word 256 wraps rom_addr to 0 but must fault
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("alias_rom_addr", {24'd0, rom_addr}, 32'd0);
    @(negedge clk);
    check("alias_fault", {31'd0, fault}, 32'd1);
    check("alias_fault_pc", fault_pc, 32'h400);

    // asynchronous reset mid-stall
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_stall_valid", {31'd0, out_valid}, 32'd1);
    check("mid_stall_rom_addr", {24'd0, rom_addr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_fault", {31'd0, fault}, 32'd0);
    check("async_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("async_out_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("async_perf_fetched", perf_fetched, 32'd0);
    check("async_perf_stalled", perf_stalled, 32'd0);
    check("async_perf_flushed", perf_flushed, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_pc", out_pc, 32'h0);
    repeat (4) @(negedge clk);
    check("post_rst_pc4", out_pc, 32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
